// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the program-counter block.
//   pc_state_t  : RUN / FAULT control states
//   redir_src_t : which source won the next-PC select (debug visibility)
//   PC_STEP     : sequential fetch increment
//   ALIGN_MASK  : low address bits that must be zero on a word target
package mips_pc_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } pc_state_t;

  typedef enum logic [1:0] {
    SRC_SEQ = 2'd0,
    SRC_BR  = 2'd1,
    SRC_J   = 2'd2,
    SRC_JR  = 2'd3
  } redir_src_t;

  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/pc_target_mux.sv
// Next-PC candidate select, purely combinational.
// Priority: jr > jump > branch > sequential.
// Ports:
//   pc_plus4      in  : pc + 4, base for jump region and branch offset
//   jump_en       in  : j/jal taken
//   jump_target   in  : 28-bit shifted jump field
//   branch_en     in  : conditional branch taken
//   branch_offset in  : sign-extended, pre-shifted branch offset
//   jr_en         in  : jr/jalr taken
//   jr_addr       in  : register-sourced target
//   candidate     out : selected next-PC value (not yet alignment checked)
//   src           out : which source produced candidate
module pc_target_mux
  import mips_pc_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                jump_en,
  input  logic [27:0]         jump_target,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_offset,
  input  logic                jr_en,
  input  logic [PC_WIDTH-1:0] jr_addr,
  output logic [PC_WIDTH-1:0] candidate,
  output redir_src_t          src
);

  logic [PC_WIDTH-1:0] jump_full;
  logic [PC_WIDTH-1:0] branch_full;

  // Jump stays inside the 256 MB region of the delay-slot address.
  assign jump_full   = {pc_plus4[PC_WIDTH-1:28], jump_target};
  // Carry out is dropped on purpose: branch wrap-around is legal.
  assign branch_full = pc_plus4 + branch_offset;

  always_comb begin
    candidate = pc_plus4;
    src       = SRC_SEQ;
    if (jr_en) begin
      candidate = jr_addr;
      src       = SRC_JR;
    end else if (jump_en) begin
      candidate = jump_full;
      src       = SRC_J;
    end else if (branch_en) begin
      candidate = branch_full;
      src       = SRC_BR;
    end
  end

endmodule

// File: rtl/pc_next_jump.sv
// Program counter register with next-PC arbitration, alignment fault
// handling and a saturating taken-redirect counter.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | normal fetch; PC advances unless stalled
//   FAULT | misaligned redirect seen; PC frozen until fault_clr
//
// Ports:
//   clk, rst_n    in  : clock (rising edge), async active-low reset
//   stall         in  : hold PC, drop redirect requests this cycle
//   jump_en/jump_target, branch_en/branch_offset, jr_en/jr_addr
//                 in  : redirect requests and their targets
//   fault_clr     in  : pulse to leave FAULT
//   pc            out : current PC
//   pc_plus4      out : pc + 4
//   link_addr     out : return address for jal/jalr
//   fault         out : high while in FAULT
//   fault_addr    out : last misaligned target
//   redirect_cnt  out : saturating count of committed redirects
module pc_next_jump
  import mips_pc_pkg::*;
#(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 jump_en,
  input  logic [27:0]          jump_target,
  input  logic                 branch_en,
  input  logic [PC_WIDTH-1:0]  branch_offset,
  input  logic                 jr_en,
  input  logic [PC_WIDTH-1:0]  jr_addr,
  input  logic                 fault_clr,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pc_plus4,
  output logic [PC_WIDTH-1:0]  link_addr,
  output logic                 fault,
  output logic [PC_WIDTH-1:0]  fault_addr,
  output logic [CNT_WIDTH-1:0] redirect_cnt
);

  pc_state_t           state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] fault_addr_nxt;
  logic [PC_WIDTH-1:0] candidate;
  redir_src_t          src;
  logic                cnt_inc;
  logic                misaligned;

  assign pc_plus4  = pc + PC_WIDTH'(PC_STEP);
  assign link_addr = pc_plus4;
  assign fault     = (state == FAULT);

  pc_target_mux #(
    .PC_WIDTH (PC_WIDTH)
  ) u_mux (
    .pc_plus4      (pc_plus4),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .jr_en         (jr_en),
    .jr_addr       (jr_addr),
    .candidate     (candidate),
    .src           (src)
  );

  // Only the winning candidate is checked; losers are simply dropped.
  assign misaligned = (candidate[1:0] & ALIGN_MASK) != 2'b00;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    fault_addr_nxt = fault_addr;
    cnt_inc        = 1'b0;
    case (state)
      RUN: begin
        if (!stall) begin
          if (misaligned) begin
            state_nxt      = FAULT;
            fault_addr_nxt = candidate;
          end else begin
            pc_nxt  = candidate;
            cnt_inc = (src != SRC_SEQ);
          end
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      pc           <= RESET_PC;
      fault_addr   <= '0;
      redirect_cnt <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      fault_addr <= fault_addr_nxt;
      if (cnt_inc && (redirect_cnt != {CNT_WIDTH{1'b1}})) begin
        redirect_cnt <= redirect_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_next_jump.sv
module tb_pc_next_jump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump_en, branch_en, jr_en, fault_clr;
  logic [27:0] jump_target;
  logic [31:0] branch_offset, jr_addr;

  logic [31:0] pc, pc_plus4, link_addr, fault_addr;
  logic        fault;
  logic [15:0] redirect_cnt;

  logic [31:0] s_pc, s_pc_plus4, s_link_addr, s_fault_addr;
  logic        s_fault;
  logic [2:0]  s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference state
  logic [31:0] m_pc, m_fa;
  logic        m_fault;
  int          m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  pc_next_jump dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump_en(jump_en),
    .jump_target(jump_target), .branch_en(branch_en),
    .branch_offset(branch_offset), .jr_en(jr_en), .jr_addr(jr_addr),
    .fault_clr(fault_clr), .pc(pc), .pc_plus4(pc_plus4),
    .link_addr(link_addr), .fault(fault), .fault_addr(fault_addr),
    .redirect_cnt(redirect_cnt)
  );

  // Narrow-counter copy used to reach saturation quickly.
  pc_next_jump #(.CNT_WIDTH(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump_en(jump_en),
    .jump_target(jump_target), .branch_en(branch_en),
    .branch_offset(branch_offset), .jr_en(jr_en), .jr_addr(jr_addr),
    .fault_clr(fault_clr), .pc(s_pc), .pc_plus4(s_pc_plus4),
    .link_addr(s_link_addr), .fault(s_fault), .fault_addr(s_fault_addr),
    .redirect_cnt(s_cnt)
  );

  task automatic idle();
    stall = 0; jump_en = 0; branch_en = 0; jr_en = 0; fault_clr = 0;
    jump_target = '0; branch_offset = '0; jr_addr = '0;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_fa = 32'h0; m_fault = 0; m_cnt = 0; m_cnt_s = 0;
  endtask

  // Applies the architectural rules to the current inputs.
  task automatic model_step();
    logic [31:0] nxt, seq;
    bit redirect;
    seq = m_pc + 32'd4;
    if (m_fault) begin
      if (fault_clr) m_fault = 0;
    end else if (!stall) begin
      redirect = jr_en || jump_en || branch_en;
      if (jr_en)          nxt = jr_addr;
      else if (jump_en)   nxt = (seq & 32'hF000_0000) | {4'h0, jump_target};
      else if (branch_en) nxt = seq + branch_offset;
      else                nxt = seq;
      if (nxt % 4 != 0) begin
        m_fault = 1;
        m_fa    = nxt;
      end else begin
        m_pc = nxt;
        if (redirect) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_s < 7)   m_cnt_s++;
        end
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    model_reset();
    #4;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (pc !== 32'h0 || fault !== 1'b0 || redirect_cnt !== 16'd0 || fault_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h fault=%b cnt=%0d fa=%h, want 0/0/0/0", pc, fault, redirect_cnt, fault_addr);
    end
    for (int i = 1; i <= 3; i++) begin
      cycle();
      n_checks++;
      if (pc !== 32'(4 * i) || redirect_cnt !== 16'd0 || fault !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: pc=%h cnt=%0d fault=%b, want pc=%h cnt=0 fault=0", i, pc, redirect_cnt, fault, 32'(4 * i));
      end
    end
  endtask

  task automatic test_jump();
    idle(); jr_en = 1; jr_addr = 32'h1000_0040;
    cycle();
    idle(); jump_en = 1; jump_target = 28'h0ABC_DE0;
    n_checks++;
    if (pc !== 32'h1000_0040 || link_addr !== 32'h1000_0044) begin
      n_fail++;
      $display("FAIL jump_setup: pc=%h link=%h, want 10000040/10000044", pc, link_addr);
    end
    cycle();
    n_checks++;
    if (pc !== 32'h10AB_CDE0 || redirect_cnt !== 16'(m_cnt) || m_cnt != 5 - 3) begin
      n_fail++;
      $display("FAIL jump_target: pc=%h cnt=%0d, want 10abcde0 cnt=%0d", pc, redirect_cnt, m_cnt);
    end
  endtask

  task automatic test_jr_priority();
    int c0;
    idle(); jr_en = 1; jr_addr = 32'h0000_0100;
    cycle();
    c0 = m_cnt;
    idle(); jr_en = 1; jr_addr = 32'h0000_2000; branch_en = 1; branch_offset = 32'hFFFF_FFF0;
    cycle();
    n_checks++;
    if (pc !== 32'h0000_2000 || redirect_cnt !== 16'(c0 + 1)) begin
      n_fail++;
      $display("FAIL jr_over_branch: pc=%h cnt=%0d, want 00002000 cnt=%0d", pc, redirect_cnt, c0 + 1);
    end
    idle(); branch_en = 1; branch_offset = 32'hFFFF_FFF0;
    cycle();
    n_checks++;
    if (pc !== 32'h0000_1FF4 || redirect_cnt !== 16'(c0 + 2)) begin
      n_fail++;
      $display("FAIL branch_back: pc=%h cnt=%0d, want 00001ff4 cnt=%0d", pc, redirect_cnt, c0 + 2);
    end
  endtask

  task automatic test_stall();
    logic [31:0] p0;
    int c0;
    p0 = pc; c0 = m_cnt;
    idle(); stall = 1; jump_en = 1; jump_target = 28'h0000_400;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (pc !== p0 || redirect_cnt !== 16'(c0) || pc_plus4 !== p0 + 32'd4) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h cnt=%0d p4=%h, want %h cnt=%0d", i, pc, redirect_cnt, pc_plus4, p0, c0);
      end
    end
    stall = 0;
    cycle();
    n_checks++;
    if (pc !== ((p0 + 32'd4) & 32'hF000_0000 | 32'h0000_0400) || redirect_cnt !== 16'(c0 + 1)) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h cnt=%0d, want %h cnt=%0d", pc, redirect_cnt, m_pc, c0 + 1);
    end
  endtask

  task automatic test_fault();
    logic [31:0] p0;
    int c0;
    p0 = pc; c0 = m_cnt;
    idle(); jr_en = 1; jr_addr = 32'h0000_3002; jump_en = 1; jump_target = 28'h0000_800;
    cycle();
    n_checks++;
    if (fault !== 1'b1 || fault_addr !== 32'h0000_3002 || pc !== p0 || redirect_cnt !== 16'(c0)) begin
      n_fail++;
      $display("FAIL fault_entry: fault=%b fa=%h pc=%h cnt=%0d, want 1/00003002/%h/%0d", fault, fault_addr, pc, redirect_cnt, p0, c0);
    end
    idle(); jump_en = 1; jump_target = 28'h0000_100; branch_en = 1; branch_offset = 32'h40;
    cycle(); cycle();
    n_checks++;
    if (fault !== 1'b1 || pc !== p0 || redirect_cnt !== 16'(c0)) begin
      n_fail++;
      $display("FAIL fault_ignore: fault=%b pc=%h cnt=%0d, want 1/%h/%0d", fault, pc, redirect_cnt, p0, c0);
    end
    idle(); fault_clr = 1;
    cycle();
    n_checks++;
    if (fault !== 1'b0 || pc !== p0 || fault_addr !== 32'h0000_3002) begin
      n_fail++;
      $display("FAIL fault_clear: fault=%b pc=%h fa=%h, want 0/%h/00003002", fault, pc, fault_addr, p0);
    end
    idle();
    cycle();
    n_checks++;
    if (pc !== p0 + 32'd4 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_resume: pc=%h, want %h", pc, p0 + 32'd4);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(); jump_en = 1; jump_target = 28'(32'h100 * (i + 1));
      cycle();
    end
    idle(); jr_en = 1; jr_addr = 32'h0000_0041;
    cycle();
    idle();
    n_checks++;
    if (fault !== 1'b1 || redirect_cnt !== 16'd5) begin
      n_fail++;
      $display("FAIL async_setup: fault=%b cnt=%0d, want 1/5", fault, redirect_cnt);
    end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if (pc !== 32'h0 || redirect_cnt !== 16'd0 || fault !== 1'b0 || fault_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h cnt=%0d fault=%b fa=%h, want all 0", pc, redirect_cnt, fault, fault_addr);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle(); jump_en = 1; jump_target = 28'(32'h40 * (i + 1));
      cycle();
      n_checks++;
      if (s_cnt !== 3'(m_cnt_s) || redirect_cnt !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL saturate[%0d]: narrow=%0d wide=%0d, want %0d/%0d", i, s_cnt, redirect_cnt, m_cnt_s, m_cnt);
      end
    end
    n_checks++;
    if (s_cnt !== 3'b111) begin
      n_fail++;
      $display("FAIL saturate_hold: narrow=%0d, want 7", s_cnt);
    end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      idle();
      stall         = ($urandom_range(0, 7) == 0);
      jr_en         = ($urandom_range(0, 5) == 0);
      jump_en       = ($urandom_range(0, 4) == 0);
      branch_en     = ($urandom_range(0, 3) == 0);
      fault_clr     = ($urandom_range(0, 3) == 0);
      jr_addr       = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) jr_addr[1:0] = 2'($urandom_range(1, 3));
      jump_target   = 28'($urandom) & 28'hFFF_FFFC;
      branch_offset = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) branch_offset[0] = 1'b1;
      cycle();
      n_checks++;
      if (pc !== m_pc || fault !== m_fault || fault_addr !== m_fa ||
          redirect_cnt !== 16'(m_cnt) || link_addr !== m_pc + 32'd4) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h f=%b fa=%h cnt=%0d link=%h, want %h/%b/%h/%0d/%h",
                 i, pc, fault, fault_addr, redirect_cnt, link_addr, m_pc, m_fault, m_fa, m_cnt, m_pc + 32'd4);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_jump();
    test_jr_priority();
    test_stall();
    test_fault();
    test_async_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
